// File: rtl/id_queue_dec.sv
`timescale 1ns/1ps
// RV32I/Zicsr decode stage: DEPTH-entry fetch queue feeding a registered,
// active-low control bundle, with in-stage branch/jump resolution and redirect.
module id_queue_dec #(
    parameter int unsigned DEPTH  = 4,
    parameter bit          CSR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic [4:0]  rs1_idx,
    output logic [4:0]  rs2_idx,
    input  logic [31:0] qa,
    input  logic [31:0] qb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic        alu_src_1,
    output logic        alu_src_2,
    output logic [31:0] alu_imm_1,
    output logic [31:0] alu_imm_2,
    output logic [7:0]  alu_op,
    output logic [7:0]  mem_op,
    output logic [8:0]  csr_op,
    output logic [11:0] csr_addr,
    output logic [4:0]  csr_zimm,
    output logic        gpr_we,
    output logic        illegal,
    output logic        brh_flag,
    output logic [31:0] brh_addr
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [7:0] {
        ALU_ADD  = 8'hFB,
        ALU_SUB  = 8'hFA,
        ALU_SLL  = 8'hD8,
        ALU_SLT  = 8'h7A,
        ALU_SLTU = 8'hBA,
        ALU_XOR  = 8'hFC,
        ALU_SRL  = 8'hE8,
        ALU_SRA  = 8'hF0,
        ALU_OR   = 8'hFD,
        ALU_AND  = 8'hFE,
        ALU_NOP  = 8'hF8
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        src_1;
        logic        src_2;
        logic [31:0] imm_1;
        logic [31:0] imm_2;
        alu_op_e     alu_op;
        logic [7:0]  mem_op;
        logic [8:0]  csr_op;
        logic [11:0] csr_addr;
        logic [4:0]  csr_zimm;
        logic        gpr_we;
        logic        illegal;
    } bundle_t;

    localparam bundle_t BUNDLE_IDLE = '{pc: '0, src_1: 1'b1, src_2: 1'b1, imm_1: '0, imm_2: '0,
                                        alu_op: ALU_NOP, mem_op: '1, csr_op: '1, csr_addr: '0,
                                        csr_zimm: '0, gpr_we: 1'b1, illegal: 1'b1};

    function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt, input logic is_op);
        case (f3)
            3'd0:    alu_sel = (is_op && alt) ? ALU_SUB : ALU_ADD;
            3'd1:    alu_sel = ALU_SLL;
            3'd2:    alu_sel = ALU_SLT;
            3'd3:    alu_sel = ALU_SLTU;
            3'd4:    alu_sel = ALU_XOR;
            3'd5:    alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    bundle_t       bundle_q, bundle_d, dec;
    logic          brh_flag_q, brh_flag_d;
    logic [31:0]   brh_addr_q, brh_addr_d;

    logic [31:0] head_pc, head_inst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        rd_nz, legal, is_jump, is_branch, br_cond, dec_redirect;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, tgt_base, tgt_off, tgt;
    logic        push, issue, redirect;

    assign head_pc   = pc_mem_q[rd_ptr_q];
    assign head_inst = inst_mem_q[rd_ptr_q];
    assign opc       = head_inst[6:0];
    assign f3        = head_inst[14:12];
    assign rd_nz     = head_inst[11:7] != 5'd0;
    assign rs1_idx   = head_inst[19:15];
    assign rs2_idx   = head_inst[24:20];

    assign imm_i = {{20{head_inst[31]}}, head_inst[31:20]};
    assign imm_s = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
    assign imm_b = {{19{head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25],
                    head_inst[11:8], 1'b0};
    assign imm_u = {head_inst[31:12], 12'd0};
    assign imm_j = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20],
                    head_inst[30:21], 1'b0};

    always_comb begin
        dec          = BUNDLE_IDLE;
        dec.pc       = head_pc;
        dec.csr_addr = head_inst[31:20];
        dec.csr_zimm = head_inst[19:15];
        legal        = 1'b1;
        is_jump      = 1'b0;
        is_branch    = 1'b0;
        br_cond      = 1'b0;
        tgt_base     = head_pc;
        tgt_off      = '0;
        case (opc)
            OPC_LUI: begin
                dec.alu_op = ALU_ADD; dec.imm_2 = imm_u; dec.gpr_we = ~rd_nz;
            end
            OPC_AUIPC: begin
                dec.alu_op = ALU_ADD; dec.imm_1 = head_pc; dec.imm_2 = imm_u; dec.gpr_we = ~rd_nz;
            end
            OPC_JAL: begin
                dec.alu_op = ALU_ADD; dec.imm_1 = head_pc; dec.imm_2 = 32'd4; dec.gpr_we = ~rd_nz;
                is_jump = 1'b1; tgt_off = imm_j;
            end
            OPC_JALR: begin
                dec.alu_op = ALU_ADD; dec.imm_1 = head_pc; dec.imm_2 = 32'd4; dec.gpr_we = ~rd_nz;
                is_jump = 1'b1; tgt_base = qa; tgt_off = imm_i;
            end
            OPC_BRANCH: begin
                dec.alu_op = ALU_SUB; dec.src_1 = 1'b0; dec.src_2 = 1'b0; dec.imm_2 = imm_b;
                is_branch = 1'b1; tgt_off = imm_b;
                case (f3)
                    3'd0:    br_cond = qa == qb;
                    3'd1:    br_cond = qa != qb;
                    3'd4:    br_cond = $signed(qa) < $signed(qb);
                    3'd5:    br_cond = $signed(qa) >= $signed(qb);
                    3'd6:    br_cond = qa < qb;
                    3'd7:    br_cond = qa >= qb;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.alu_op = ALU_ADD; dec.src_1 = 1'b0; dec.imm_2 = imm_i; dec.gpr_we = ~rd_nz;
                case (f3)
                    3'd0:    dec.mem_op[7] = 1'b0;
                    3'd1:    dec.mem_op[6] = 1'b0;
                    3'd2:    dec.mem_op[5] = 1'b0;
                    3'd4:    dec.mem_op[4] = 1'b0;
                    3'd5:    dec.mem_op[3] = 1'b0;
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                dec.alu_op = ALU_ADD; dec.src_1 = 1'b0; dec.imm_2 = imm_s;
                case (f3)
                    3'd0:    dec.mem_op[2] = 1'b0;
                    3'd1:    dec.mem_op[1] = 1'b0;
                    3'd2:    dec.mem_op[0] = 1'b0;
                    default: legal = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                dec.alu_op = alu_sel(f3, head_inst[30], 1'b0);
                dec.src_1 = 1'b0; dec.imm_2 = imm_i; dec.gpr_we = ~rd_nz;
            end
            OPC_OP: begin
                dec.alu_op = alu_sel(f3, head_inst[30], 1'b1);
                dec.src_1 = 1'b0; dec.src_2 = 1'b0; dec.gpr_we = ~rd_nz;
            end
            OPC_SYSTEM: begin
                if (!CSR_EN) begin
                    legal = 1'b0;
                end else begin
                    case (f3)
                        3'd0: begin
                            case (head_inst[22:20])
                                3'd0:    dec.csr_op[8] = 1'b0;
                                3'd1:    dec.csr_op[7] = 1'b0;
                                3'd2:    dec.csr_op[6] = 1'b0;
                                default: ;
                            endcase
                        end
                        3'd1:    begin dec.csr_op[5] = 1'b0; dec.gpr_we = ~rd_nz; end
                        3'd2:    begin dec.csr_op[4] = 1'b0; dec.gpr_we = ~rd_nz; end
                        3'd3:    begin dec.csr_op[3] = 1'b0; dec.gpr_we = ~rd_nz; end
                        3'd5:    begin dec.csr_op[2] = 1'b0; dec.gpr_we = ~rd_nz; end
                        3'd6:    begin dec.csr_op[1] = 1'b0; dec.gpr_we = ~rd_nz; end
                        3'd7:    begin dec.csr_op[0] = 1'b0; dec.gpr_we = ~rd_nz; end
                        default: legal = 1'b0;
                    endcase
                end
            end
            default: legal = 1'b0;
        endcase
        if (head_inst[1:0] != 2'b11) legal = 1'b0;
        // Illegal words fall back to the idle bundle but keep pc/csr fields for the trap handler.
        if (!legal) begin
            dec          = BUNDLE_IDLE;
            dec.pc       = head_pc;
            dec.csr_addr = head_inst[31:20];
            dec.csr_zimm = head_inst[19:15];
            dec.illegal  = 1'b0;
            is_jump      = 1'b0;
            is_branch    = 1'b0;
        end
        dec_redirect = is_jump || (is_branch && br_cond);
    end

    assign tgt      = (tgt_base + tgt_off) & ~32'd1;
    assign in_ready = count_q < CW'(DEPTH);
    assign issue    = flush_n && (count_q != '0) && (!out_valid_q || out_ready);
    assign redirect = issue && dec_redirect;
    assign push     = in_valid && in_ready && flush_n && !redirect;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!flush_n || redirect) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
            if (issue) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(issue);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        brh_flag_d  = ~redirect;
        brh_addr_d  = redirect ? tgt : brh_addr_q;
        if (!flush_n) begin
            out_valid_d = 1'b0;
            bundle_d    = BUNDLE_IDLE;
        end else if (issue) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            bundle_d    = BUNDLE_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= in_pc;
            inst_mem_q[wr_ptr_q] <= in_inst;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            bundle_q    <= BUNDLE_IDLE;
            brh_flag_q  <= 1'b1;
            brh_addr_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            brh_flag_q  <= brh_flag_d;
            brh_addr_q  <= brh_addr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = bundle_q.pc;
    assign alu_src_1 = bundle_q.src_1;
    assign alu_src_2 = bundle_q.src_2;
    assign alu_imm_1 = bundle_q.imm_1;
    assign alu_imm_2 = bundle_q.imm_2;
    assign alu_op    = bundle_q.alu_op;
    assign mem_op    = bundle_q.mem_op;
    assign csr_op    = bundle_q.csr_op;
    assign csr_addr  = bundle_q.csr_addr;
    assign csr_zimm  = bundle_q.csr_zimm;
    assign gpr_we    = bundle_q.gpr_we;
    assign illegal   = bundle_q.illegal;
    assign brh_flag  = brh_flag_q;
    assign brh_addr  = brh_addr_q;

endmodule

// File: tb/tb_id_queue_dec.sv
`timescale 1ns/1ps
// Directed bench for id_queue_dec: queue fill/drain, ALU decode, branches,
// jalr, illegal words, CSR decode, flush priority and asynchronous reset.
module tb_id_queue_dec;
    logic        clk = 1'b0, rst = 1'b0, flush_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_pc = '0, in_inst = '0, qa = '0, qb = '0;
    logic        in_ready, out_valid, alu_src_1, alu_src_2, gpr_we, illegal, brh_flag;
    logic [4:0]  rs1_idx, rs2_idx, csr_zimm;
    logic [31:0] out_pc, alu_imm_1, alu_imm_2, brh_addr;
    logic [7:0]  alu_op, mem_op;
    logic [8:0]  csr_op;
    logic [11:0] csr_addr;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    id_queue_dec #(.DEPTH(4), .CSR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush_n(flush_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .qa(qa), .qb(qb),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .alu_src_1(alu_src_1),
        .alu_src_2(alu_src_2), .alu_imm_1(alu_imm_1), .alu_imm_2(alu_imm_2), .alu_op(alu_op),
        .mem_op(mem_op), .csr_op(csr_op), .csr_addr(csr_addr), .csr_zimm(csr_zimm),
        .gpr_we(gpr_we), .illegal(illegal), .brh_flag(brh_flag), .brh_addr(brh_addr)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (alu_op !== 8'hF8) begin errors++; $display("FAIL rst_alu_op got %h want f8", alu_op); end
        checks++; if (mem_op !== 8'hFF) begin errors++; $display("FAIL rst_mem_op got %h want ff", mem_op); end
        checks++; if (csr_op !== 9'h1FF) begin errors++; $display("FAIL rst_csr_op got %h want 1ff", csr_op); end
        checks++; if ({gpr_we, illegal, brh_flag, alu_src_1, alu_src_2} !== 5'b11111) begin
            errors++; $display("FAIL rst_flags got %b want 11111", {gpr_we, illegal, brh_flag, alu_src_1, alu_src_2}); end
        checks++; if ({brh_addr, out_pc, alu_imm_1, alu_imm_2} !== 128'd0) begin
            errors++; $display("FAIL rst_words got %h %h %h %h want 0", brh_addr, out_pc, alu_imm_1, alu_imm_2); end
        checks++; if ({csr_addr, csr_zimm} !== 17'd0) begin errors++; $display("FAIL rst_csr_fields got %h want 0", {csr_addr, csr_zimm}); end
        rst = 1'b1;
    endtask

    task automatic test_fill();
        logic [31:0] fill_inst [6];
        logic [7:0]  fill_alu  [6];
        fill_inst = '{32'h00000093, 32'h00004113, 32'h00006193, 32'h00007213, 32'h00002293, 32'h00003313};
        fill_alu  = '{8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'h7A, 8'hBA};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_pc   = 32'h1000 + 32'(4 * i);
            in_inst = fill_inst[i];
            cyc();
            if (i == 0) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_latency got %b want 0", out_valid); end
            end
            if (i == 1) begin
                checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1000) begin
                    errors++; $display("FAIL fill_first got v=%b pc=%h want v=1 pc=1000", out_valid, out_pc); end
            end
            if (i == 3) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready3 got %b want 1", in_ready); end
            end
            if (i >= 4) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full%0d got %b want 0", i, in_ready); end
            end
        end
        checks++; if (out_pc !== 32'h1000 || alu_op !== 8'hFB) begin
            errors++; $display("FAIL fill_hold got pc=%h op=%h want pc=1000 op=fb", out_pc, alu_op); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cyc();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1004 + 32'(4 * j) || alu_op !== fill_alu[j + 1]) begin
                errors++; $display("FAIL drain%0d got v=%b pc=%h op=%h want v=1 pc=%h op=%h", j, out_valid, out_pc,
                                   alu_op, 32'h1004 + 32'(4 * j), fill_alu[j + 1]); end
        end
        cyc();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL drain_end got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    endtask

    task automatic test_alu_rr();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc = 32'h10; in_inst = 32'h003100B3;
        cyc();
        checks++; if (rs2_idx !== 5'd3) begin errors++; $display("FAIL add_rs2_idx got %0d want 3", rs2_idx); end
        in_pc = 32'h14; in_inst = 32'h40628233;
        cyc();
        checks++; if (alu_op !== 8'hFB || out_pc !== 32'h10 || out_valid !== 1'b1) begin
            errors++; $display("FAIL add_issue got op=%h pc=%h v=%b want op=fb pc=10 v=1", alu_op, out_pc, out_valid); end
        checks++; if ({alu_src_1, alu_src_2, gpr_we} !== 3'b000) begin
            errors++; $display("FAIL add_ctrl got %b want 000", {alu_src_1, alu_src_2, gpr_we}); end
        in_valid = 1'b0;
        cyc();
        checks++; if (alu_op !== 8'hFA || out_pc !== 32'h14 || out_valid !== 1'b1 || gpr_we !== 1'b0) begin
            errors++; $display("FAIL sub_issue got op=%h pc=%h v=%b we=%b want op=fa pc=14 v=1 we=0", alu_op, out_pc, out_valid, gpr_we); end
        cyc();
        checks++; if (out_valid !== 1'b0 || alu_op !== 8'hF8) begin
            errors++; $display("FAIL rr_idle got v=%b op=%h want v=0 op=f8", out_valid, alu_op); end
    endtask

    task automatic test_branch(input logic taken);
        int nvalid;
        logic [31:0] last_pc;
        nvalid = 0;
        last_pc = '0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc = 32'hFC;  in_inst = 32'h00000093; cyc();
        in_pc = 32'h100; in_inst = 32'h00208863; cyc();
        in_pc = 32'h104; in_inst = 32'h00100293; cyc();
        in_pc = 32'h108; in_inst = 32'h00200313; cyc();
        in_pc = 32'h10C; in_inst = 32'h00300393; cyc();
        in_valid  = 1'b0;
        qa = 32'd5;
        qb = taken ? 32'd5 : 32'd6;
        out_ready = 1'b1;
        cyc();
        checks++; if (out_pc !== 32'h100 || alu_op !== 8'hFA || {alu_src_1, alu_src_2, gpr_we} !== 3'b001) begin
            errors++; $display("FAIL beq_issue_t%0d got pc=%h op=%h ctl=%b want pc=100 op=fa ctl=001", taken, out_pc,
                               alu_op, {alu_src_1, alu_src_2, gpr_we}); end
        checks++; if (brh_flag !== ~taken) begin errors++; $display("FAIL beq_flag_t%0d got %b want %b", taken, brh_flag, ~taken); end
        checks++; if (brh_addr !== 32'h110) begin errors++; $display("FAIL beq_addr_t%0d got %h want 110", taken, brh_addr); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 0) begin
                checks++; if (brh_flag !== 1'b1) begin errors++; $display("FAIL beq_pulse_t%0d got %b want 1", taken, brh_flag); end
            end
            if (out_valid === 1'b1) begin
                nvalid++;
                last_pc = out_pc;
            end
        end
        checks++; if (nvalid !== (taken ? 0 : 3)) begin
            errors++; $display("FAIL beq_younger_t%0d got %0d want %0d", taken, nvalid, taken ? 0 : 3); end
        checks++; if (last_pc !== (taken ? 32'h0 : 32'h10C)) begin
            errors++; $display("FAIL beq_last_pc_t%0d got %h want %h", taken, last_pc, taken ? 32'h0 : 32'h10C); end
    endtask

    task automatic test_jalr();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc = 32'h40; in_inst = 32'h007100E7;
        qa = 32'h2000;
        cyc();
        checks++; if (rs1_idx !== 5'd2) begin errors++; $display("FAIL jalr_rs1_idx got %0d want 2", rs1_idx); end
        in_valid = 1'b0;
        cyc();
        checks++; if (brh_flag !== 1'b0 || brh_addr !== 32'h2006) begin
            errors++; $display("FAIL jalr_redirect got f=%b a=%h want f=0 a=2006", brh_flag, brh_addr); end
        checks++; if (alu_imm_1 !== 32'h40 || alu_imm_2 !== 32'd4 || gpr_we !== 1'b0 || alu_op !== 8'hFB) begin
            errors++; $display("FAIL jalr_bundle got i1=%h i2=%h we=%b op=%h want i1=40 i2=4 we=0 op=fb", alu_imm_1,
                               alu_imm_2, gpr_we, alu_op); end
        cyc();
        checks++; if (brh_flag !== 1'b1 || brh_addr !== 32'h2006) begin
            errors++; $display("FAIL jalr_after got f=%b a=%h want f=1 a=2006", brh_flag, brh_addr); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc = 32'h200; in_inst = 32'h00003003; cyc();
        in_pc = 32'h204; in_inst = 32'h00000013; cyc();
        checks++; if (illegal !== 1'b0 || mem_op !== 8'hFF || gpr_we !== 1'b1 || alu_op !== 8'hF8) begin
            errors++; $display("FAIL ld_illegal got ill=%b mem=%h we=%b op=%h want ill=0 mem=ff we=1 op=f8", illegal,
                               mem_op, gpr_we, alu_op); end
        checks++; if (brh_flag !== 1'b1 || out_pc !== 32'h200 || out_valid !== 1'b1) begin
            errors++; $display("FAIL ld_issue got f=%b pc=%h v=%b want f=1 pc=200 v=1", brh_flag, out_pc, out_valid); end
        in_pc = 32'h208; in_inst = 32'h00012083; cyc();
        checks++; if (gpr_we !== 1'b1 || illegal !== 1'b1 || alu_op !== 8'hFB) begin
            errors++; $display("FAIL addi_x0 got we=%b ill=%b op=%h want we=1 ill=1 op=fb", gpr_we, illegal, alu_op); end
        in_valid = 1'b0;
        cyc();
        checks++; if (mem_op !== 8'hDF || gpr_we !== 1'b0 || {alu_src_1, alu_src_2} !== 2'b01) begin
            errors++; $display("FAIL lw_decode got mem=%h we=%b src=%b want mem=df we=0 src=01", mem_op, gpr_we,
                               {alu_src_1, alu_src_2}); end
        cyc();
    endtask

    task automatic test_csr();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc = 32'h300; in_inst = 32'h300110F3; cyc();
        in_pc = 32'h304; in_inst = 32'h00100073; cyc();
        checks++; if (csr_op !== 9'h1DF || csr_addr !== 12'h300 || csr_zimm !== 5'd2 || gpr_we !== 1'b0) begin
            errors++; $display("FAIL csrrw got op=%h addr=%h zimm=%0d we=%b want op=1df addr=300 zimm=2 we=0", csr_op,
                               csr_addr, csr_zimm, gpr_we); end
        in_valid = 1'b0;
        cyc();
        checks++; if (csr_op !== 9'h17F || gpr_we !== 1'b1 || illegal !== 1'b1) begin
            errors++; $display("FAIL ebreak got op=%h we=%b ill=%b want op=17f we=1 ill=1", csr_op, gpr_we, illegal); end
        cyc();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        qa = 32'd7; qb = 32'd7;
        in_pc = 32'h500; in_inst = 32'h00208863; cyc();
        flush_n = 1'b0;
        in_pc = 32'h504; in_inst = 32'h00000093; cyc();
        checks++; if (out_valid !== 1'b0 || brh_flag !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_edge got v=%b f=%b rdy=%b want v=0 f=1 rdy=1", out_valid, brh_flag, in_ready); end
        checks++; if (brh_addr !== 32'h2006) begin errors++; $display("FAIL flush_addr got %h want 2006", brh_addr); end
        flush_n  = 1'b1;
        in_valid = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0 || brh_flag !== 1'b1) begin
            errors++; $display("FAIL flush_after got v=%b f=%b want v=0 f=1", out_valid, brh_flag); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc = 32'h300; in_inst = 32'h0080006F; cyc();
        in_valid = 1'b0;
        cyc();
        checks++; if (brh_flag !== 1'b0 || brh_addr !== 32'h308 || gpr_we !== 1'b1) begin
            errors++; $display("FAIL jal_x0 got f=%b a=%h we=%b want f=0 a=308 we=1", brh_flag, brh_addr, gpr_we); end
        #2 rst = 1'b0;
        #1;
        checks++; if (brh_flag !== 1'b1 || brh_addr !== 32'h0 || out_valid !== 1'b0 || alu_op !== 8'hF8 || in_ready !== 1'b1) begin
            errors++; $display("FAIL async_rst got f=%b a=%h v=%b op=%h rdy=%b want f=1 a=0 v=0 op=f8 rdy=1", brh_flag,
                               brh_addr, out_valid, alu_op, in_ready); end
        rst = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_alu_rr();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jalr();
        test_illegal();
        test_csr();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
